// File: rtl/y86_pkg.sv
// Shared encodings for the multi-cycle Y86 core: opcodes, ALU functions,
// branch/move conditions, status codes and the sequencer state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [1:0] ST_AOK = 2'd0;
    localparam logic [1:0] ST_HLT = 2'd1;
    localparam logic [1:0] ST_INS = 2'd2;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Evaluate a jump/cmov condition against flags {ZF,SF,OF}.
    function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] flags);
        logic zf, sf, of;
        zf = flags[2];
        sf = flags[1];
        of = flags[0];
        case (fn)
            C_ALWAYS: return 1'b1;
            C_LE:     return (sf ^ of) | zf;
            C_L:      return sf ^ of;
            C_E:      return zf;
            C_NE:     return ~zf;
            C_GE:     return ~(sf ^ of);
            C_G:      return ~(sf ^ of) & ~zf;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_regfile_p.sv
// Architectural register file: two combinational read ports, one debug read
// port and one synchronous write port. IDs >= NREG (including 0xF) read as 0
// and are never written.
module y86_regfile_p #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ra_sel,
    output logic [DATA_W-1:0] ra_val,
    input  logic [3:0]        rb_sel,
    output logic [DATA_W-1:0] rb_val,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val,
    input  logic              we,
    input  logic [3:0]        wsel,
    input  logic [DATA_W-1:0] wval
);

    localparam logic [4:0] NREG5 = 5'(NREG);

    // Sized to the full 4-bit ID space so any ID indexes cleanly; entries at
    // or above NREG are never written and stay constant zero.
    logic [DATA_W-1:0] mem [16];

    function automatic logic in_range(input logic [3:0] id);
        return {1'b0, id} < NREG5;
    endfunction

    assign ra_val  = in_range(ra_sel)  ? mem[ra_sel]  : '0;
    assign rb_val  = in_range(rb_sel)  ? mem[rb_sel]  : '0;
    assign dbg_val = in_range(dbg_sel) ? mem[dbg_sel] : '0;

    // Clear on reset, otherwise single write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (we && in_range(wsel)) begin
            mem[wsel] <= wval;
        end
    end

endmodule

// File: rtl/y86_multicycle_core.sv
// Multi-cycle Y86 core: FETCH/DECODE/EXEC/WB sequencer over a req/ack
// instruction port, with PC, register file, condition codes, status and a
// retired-instruction counter.
module y86_multicycle_core
    import y86_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int NREG     = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [47:0]       imem_data,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        status,
    output logic [2:0]        cc,
    output logic [CNT_W-1:0]  retired,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    localparam logic [4:0] NREG5 = 5'(NREG);

    state_t state, state_nxt;

    logic [47:0]       ir;
    logic [DATA_W-1:0] val_a, val_b, val_c, val_e;
    logic              cnd;

    logic [3:0] icode, ifun, ra, rb;
    assign icode = ir[47:44];
    assign ifun  = ir[43:40];
    assign ra    = ir[39:36];
    assign rb    = ir[35:32];

    // Little-endian immediate: bytes 2..5 for irmovl, bytes 1..4 for jXX.
    logic [31:0]       c32;
    logic [DATA_W-1:0] c_ext;
    assign c32   = (icode == IJXX) ? {ir[15:8], ir[23:16], ir[31:24], ir[39:32]}
                                   : {ir[7:0],  ir[15:8],  ir[23:16], ir[31:24]};
    assign c_ext = DATA_W'($signed(c32));

    logic [DATA_W-1:0] rf_a, rf_b;
    logic              rf_we;

    y86_regfile_p #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk     (CLK),
        .rst     (RESET),
        .ra_sel  (ra),
        .ra_val  (rf_a),
        .rb_sel  (rb),
        .rb_val  (rf_b),
        .dbg_sel (dbg_sel),
        .dbg_val (dbg_val),
        .we      (rf_we),
        .wsel    (rb),
        .wval    (val_e)
    );

    function automatic logic reg_ok(input logic [3:0] id);
        return {1'b0, id} < NREG5;
    endfunction

    // Instruction legality: opcode, function code and register-ID checks.
    logic dec_ok;
    always_comb begin
        dec_ok = 1'b0;
        case (icode)
            IHALT, INOP: dec_ok = 1'b1;
            IRRMOVL:     dec_ok = (ifun <= 4'd6) && reg_ok(ra) && reg_ok(rb);
            IIRMOVL:     dec_ok = (ra == RNONE) && reg_ok(rb);
            IOPL:        dec_ok = (ifun <= 4'd3) && reg_ok(ra) && reg_ok(rb);
            IJXX:        dec_ok = (ifun <= 4'd6);
            default:     dec_ok = 1'b0;
        endcase
    end

    // ALU and signed-overflow detection; OF is only meaningful for add/sub.
    logic [DATA_W-1:0] alu;
    logic              alu_of;
    always_comb begin
        alu    = val_b + val_a;
        alu_of = 1'b0;
        case (ifun)
            ALU_ADD: begin
                alu    = val_b + val_a;
                alu_of = (val_a[DATA_W-1] == val_b[DATA_W-1]) && (alu[DATA_W-1] != val_b[DATA_W-1]);
            end
            ALU_SUB: begin
                alu    = val_b - val_a;
                alu_of = (val_a[DATA_W-1] != val_b[DATA_W-1]) && (alu[DATA_W-1] != val_b[DATA_W-1]);
            end
            ALU_AND: alu = val_b & val_a;
            ALU_XOR: alu = val_b ^ val_a;
            default: ;
        endcase
    end

    // Select the value to be written back.
    logic [DATA_W-1:0] exec_val;
    always_comb begin
        case (icode)
            IRRMOVL: exec_val = val_a;
            IOPL:    exec_val = alu;
            default: exec_val = val_c;
        endcase
    end

    // Sequential length of the current instruction.
    logic [ADDR_W-1:0] val_p;
    always_comb begin
        case (icode)
            IRRMOVL, IOPL: val_p = ADDR_W'(2);
            IIRMOVL:       val_p = ADDR_W'(6);
            IJXX:          val_p = ADDR_W'(5);
            default:       val_p = ADDR_W'(1);
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (!dec_ok || icode == IHALT) ? S_STOP : S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            default:  state_nxt = S_STOP;
        endcase
    end

    // State-decoded outputs: fetch request and register write enable.
    always_comb begin
        imem_req = (state == S_FETCH) && !RESET;
        rf_we    = (state == S_WB) &&
                   (icode == IOPL || icode == IIRMOVL || (icode == IRRMOVL && cnd));
    end

    assign imem_addr = pc;

    // Datapath registers, advanced by the phase of the current instruction.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc      <= ADDR_W'(RESET_PC);
            ir      <= '0;
            cc      <= 3'b100;
            status  <= ST_AOK;
            retired <= '0;
            val_a   <= '0;
            val_b   <= '0;
            val_c   <= '0;
            val_e   <= '0;
            cnd     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_data;
                S_DECODE: begin
                    val_a <= rf_a;
                    val_b <= rf_b;
                    val_c <= c_ext;
                    if (!dec_ok)              status <= ST_INS;
                    else if (icode == IHALT)  status <= ST_HLT;
                end
                S_EXEC: begin
                    val_e <= exec_val;
                    // Condition sees the flags from before this instruction.
                    cnd   <= cond_eval(ifun, cc);
                    if (icode == IOPL) cc <= {alu == '0, alu[DATA_W-1], alu_of};
                end
                S_WB: begin
                    pc      <= (icode == IJXX && cnd) ? ADDR_W'(val_c) : pc + val_p;
                    retired <= retired + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
